bus_dma_master: RTL and testbench
=================================

# bus_dma_master

Bus-master copy engine on the master side of the shared 32-bit / 8-bit-address bus. Once started, it requests the bus, waits for grant, and moves a block of words from a source address range to a destination range. Each word is a single read followed by a single write. It is the initiator the bus arbiter and slave decode serve, letting S0 (0x00–0x1F) and S1 (0x20–0x3F) exchange data without an external master.

## Interface
- ADDR_W, 8, bus address width
- DATA_W, 32, bus data width
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that launches a transfer; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address, captured on start
- dst_addr  in  ADDR_W  first destination word address, captured on start
- len  in  8  word count, captured on start; 0 means no transfer
- fill  in  1  fill mode select, captured on start (see Configuration)
- fill_data  in  DATA_W  constant written in fill mode, captured on start
- M_grant  in  1  bus grant from the arbiter
- M_din  in  DATA_W  read data returned by the bus
- M_req  out  1  bus request
- M_wr  out  1  1 = write cycle, 0 = read cycle
- M_addr  out  ADDR_W  bus address
- M_dout  out  DATA_W  write data
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, REQ, RD, RDW, WR, DONE.
- IDLE: all outputs 0. If start=1, capture src, dst, len, fill and fill_data, and clear the word index i.
  - If len=0, go to DONE.
  - Otherwise go to REQ.
- REQ: M_req=1, M_wr=0. If M_grant=1, go to RD (or to WR in fill mode); otherwise hold.
- RD: M_addr = src+i, M_wr=0. Go to RDW.
- RDW: M_addr = src+i held. M_din is valid in this cycle and is latched into the data register at the closing edge. Go to WR.
- WR: M_addr = dst+i, M_wr=1, M_dout = data register (or fill_data). Increment i.
  - If i+1 = len, go to DONE.
  - Otherwise go to RD (or to WR in fill mode).
- DONE: done=1, M_req=0. Go to IDLE.
- M_req stays high continuously from REQ through the last WR.
- Grant loss: if M_grant=0 in RD, RDW or WR, that cycle has no effect. i and the data register are unchanged, and the state goes to REQ. Once regranted, the engine restarts at RD for the same i, so the interrupted word is re-read.
- Address arithmetic is mod 2^ADDR_W: 0xFF+1 wraps to 0x00.
- start while busy is ignored. Input changes after the start cycle have no effect.
- reset_n low at any time, including mid-word, sends the FSM to IDLE immediately and clears all outputs. No partial write completes after reset.

## Timing
- Reset values: M_req=0, M_wr=0, M_addr=0x00, M_dout=0, busy=0, done=0.
- start sampled at edge T: busy=1 and M_req=1 from T+1.
- Read latency: M_din is valid one cycle after the read address is presented.
- Copy mode: 3 cycles per word once granted. Fill mode: 1 cycle per word.
- With immediate grant, len=N takes 1 (REQ) + 3N + 1 (DONE) cycles after start. done is high in the last of these cycles; busy falls together with done.
- len=0: done pulses at T+1, M_req never asserts.
- All outputs are registered or decoded from the state register only; no combinational path from M_din.

## Configuration
- DMA_FILL_EN defined: fill=1 skips RD/RDW and writes fill_data to dst..dst+len-1, one word per granted cycle.
- DMA_FILL_EN undefined: fill and fill_data are ignored, and every transfer is a copy.

## Test plan
- Reset mid-transfer: copy in progress, reset_n pulled low during a WR -> all outputs 0 at once, no further writes; a new start after release runs correctly.
- Basic copy: S0 holds 0x1,0x2,0x3,0x4 at 0x00–0x03; start with src=0x00, dst=0x20, len=4 -> S1 0x20–0x23 holds 1,2,3,4; done pulses 14 cycles after start; M_wr high only in WR cycles.
- len=0 and start while busy: len=0 -> done at T+1 with M_req never high; a second start during a copy -> ignored, transfer unchanged.
- Wrap-around: src=0xFE, len=3 -> reads 0xFE, 0xFF, 0x00.
- Grant withdrawal: M_grant held low 3 cycles after REQ, then dropped for 2 cycles during the 2nd word's RDW -> same word re-read, final destination contents correct, no duplicate or skipped write.
- Fill (DMA_FILL_EN defined): fill=1, fill_data=0xDEADBEEF, dst=0x20, len=3 -> 0x20–0x22 = 0xDEADBEEF, one write per cycle, no read cycles. Without DMA_FILL_EN the same stimulus performs a copy.

Source files
------------

// File: rtl/bus_dma_master.sv
// bus_dma_master: bus-master block copy engine for the shared 32-bit data / 8-bit address bus.
// Each word is moved as one read followed by one write. The engine requests the bus, waits
// for grant, and re-reads the current word whenever grant is withdrawn before its write lands.
// Optional feature macro: DMA_FILL_EN. When it is defined, fill=1 writes a constant to the
// destination range, one word per granted cycle. When it is undefined, every transfer is a copy.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; all outputs low
// REQ   | requesting the bus; entered on launch and after any grant loss
// RD    | read address src+i on the bus
// RDW   | read data returned on M_din; it is captured at the closing edge
// WR    | write address dst+i with the captured word (or the fill constant)
// DONE  | one-cycle completion pulse
module bus_dma_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [7:0]        len,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              M_grant,
  input  logic [DATA_W-1:0] M_din,
  output logic              M_req,
  output logic              M_wr,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_dout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    RDW  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        len_q;
  logic [7:0]        idx;
  logic [7:0]        idx_nxt;
  logic [ADDR_W-1:0] src_cur;
  logic [ADDR_W-1:0] dst_cur;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic              fill_mode;
  logic [DATA_W-1:0] fill_word;

  // Address arithmetic wraps naturally at the bus address width.
  assign idx_nxt = idx + 8'd1;
  assign src_cur = src_q + ADDR_W'(idx);
  assign dst_cur = dst_q + ADDR_W'(idx);
  assign src_nxt = src_q + ADDR_W'(idx_nxt);
  assign dst_nxt = dst_q + ADDR_W'(idx_nxt);

`ifdef DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_data_q;

  // Fill mode and the fill constant are captured with the rest of the launch parameters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (state == IDLE && start) begin
      fill_q      <= fill;
      fill_data_q <= fill_data;
    end
  end

  assign fill_mode = fill_q;
  assign fill_word = fill_data_q;
`else
  logic unused_fill;

  assign unused_fill = ^{fill, fill_data};
  assign fill_mode   = 1'b0;
  assign fill_word   = '0;
`endif

  // Sequencer. All bus outputs are registered and set for the state being entered, so
  // M_din never reaches an output combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx    <= '0;
      M_req  <= 1'b0;
      M_wr   <= 1'b0;
      M_addr <= '0;
      M_dout <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            idx   <= '0;
            busy  <= 1'b1;
            if (len == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= REQ;
              M_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (M_grant) begin
            if (fill_mode) begin
              state  <= WR;
              M_wr   <= 1'b1;
              M_addr <= dst_cur;
              M_dout <= fill_word;
            end else begin
              state  <= RD;
              M_addr <= src_cur;
            end
          end
        end
        RD: begin
          if (M_grant) begin
            state <= RDW;
          end else begin
            state  <= REQ;
            M_addr <= '0;
          end
        end
        RDW: begin
          if (M_grant) begin
            state  <= WR;
            M_wr   <= 1'b1;
            M_addr <= dst_cur;
            M_dout <= M_din;
          end else begin
            state  <= REQ;
            M_addr <= '0;
          end
        end
        WR: begin
          if (M_grant) begin
            idx <= idx_nxt;
            if (idx_nxt == len_q) begin
              state  <= DONE;
              done   <= 1'b1;
              M_req  <= 1'b0;
              M_wr   <= 1'b0;
              M_addr <= '0;
              M_dout <= '0;
            end else if (fill_mode) begin
              M_addr <= dst_nxt;
              M_dout <= fill_word;
            end else begin
              state  <= RD;
              M_wr   <= 1'b0;
              M_addr <= src_nxt;
              M_dout <= '0;
            end
          end else begin
            // The write did not land; index stays put so the word is fetched again.
            state  <= REQ;
            M_wr   <= 1'b0;
            M_addr <= '0;
            M_dout <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          M_req  <= 1'b0;
          M_wr   <= 1'b0;
          M_addr <= '0;
          M_dout <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Testbench for bus_dma_master: a bus slave memory model answers reads, a negedge monitor
// logs every granted write, and directed steps compare those writes against an expected queue.
module tb_bus_dma_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [7:0]  len = '0;
  logic        fill = 1'b0;
  logic [31:0] fill_data = '0;
  logic        M_grant = 1'b1;
  logic [31:0] M_din;
  logic        M_req;
  logic        M_wr;
  logic [7:0]  M_addr;
  logic [31:0] M_dout;
  logic        busy;
  logic        done;

  bus_dma_master #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill(fill), .fill_data(fill_data), .M_grant(M_grant), .M_din(M_din),
    .M_req(M_req), .M_wr(M_wr), .M_addr(M_addr), .M_dout(M_dout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [39:0] exp_q [$];
  logic [39:0] obs_q [$];
  int          obs_base = 0;
  int          wr_cyc = 0;
  int          req_cyc = 0;
  int          w0 = 0;
  int          r0 = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        b1, r1;
  int          dk;

  // Read data returns one cycle after the address is presented.
  always @(posedge clk) begin
    if (M_req && M_grant && !M_wr) M_din <= mem[M_addr];
  end

  // Log granted writes and count bus activity, sampled mid-cycle.
  always @(negedge clk) begin
    if (M_req && M_grant && M_wr) obs_q.push_back({M_addr, M_dout});
    if (M_wr) wr_cyc++;
    if (M_req) req_cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] sa, da;
    for (int j = 0; j < n; j++) begin
      sa = s + 8'(j);
      da = d + 8'(j);
      exp_q.push_back({da, mem[sa]});
    end
  endtask

  task automatic check_writes(input string tag);
    int n_obs;
    int j;
    logic [39:0] e;
    n_obs = obs_q.size() - obs_base;
    chk({tag, " write count"}, 64'(n_obs), 64'(exp_q.size()));
    j = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (j < n_obs) chk($sformatf("%s write %0d", tag, j), 64'(obs_q[obs_base + j]), 64'(e));
      j++;
    end
    obs_base = obs_q.size();
  endtask

  // Called #1 after a rising edge; the start pulse is sampled on the next edge.
  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                        input logic f, input logic [31:0] fd);
    src_addr = s; dst_addr = d; len = l; fill = f; fill_data = fd; start = 1'b1;
    w0 = wr_cyc; r0 = req_cyc;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = ~s; dst_addr = ~d; len = 8'hFF; fill = ~f; fill_data = ~fd;
  endtask

  // Cycle k=1 is the cycle right after the start edge. Grant is low in [lo_a,hi_a] and [lo_b,hi_b].
  task automatic run(input int lo_a, input int hi_a, input int lo_b, input int hi_b,
                     input int rst_k, input int start_k, input int max_k, output int done_k);
    done_k = -1;
    for (int k = 1; k <= max_k; k++) begin
      M_grant = !((k >= lo_a && k <= hi_a) || (k >= lo_b && k <= hi_b));
      if (k == start_k) begin
        start = 1'b1; src_addr = 8'h30; dst_addr = 8'h3C; len = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (k == rst_k) begin
        reset_n = 1'b0;
        #1;
        chk("outputs at reset assert", {M_req, M_wr, M_addr, M_dout, busy, done}, 64'h0);
      end
      @(negedge clk);
      if (k == 1) begin b1 = busy; r1 = M_req; end
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    M_grant = 1'b1;
    start = 1'b0;
  endtask

  task automatic post_done(input string tag);
    @(posedge clk); #1;
    chk({tag, " idle after done"}, {60'h0, done, busy, M_req, M_wr}, 64'h0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'hA500_0000 | 32'(a);
    mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3; mem[3] = 32'h4;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset M_req", 64'(M_req), 64'h0);
    chk("reset M_wr", 64'(M_wr), 64'h0);
    chk("reset M_addr", 64'(M_addr), 64'h0);
    chk("reset M_dout", 64'(M_dout), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic copy S0 0x00..0x03 -> S1 0x20..0x23
    push_copy(8'h00, 8'h20, 4);
    launch(8'h00, 8'h20, 8'd4, 1'b0, 32'h0);
    run(0, -1, 0, -1, 0, 0, 40, dk);
    chk("basic done cycle", 64'(dk), 64'd14);
    chk("basic busy at T+1", 64'(b1), 64'h1);
    chk("basic req at T+1", 64'(r1), 64'h1);
    chk("basic wr cycles", 64'(wr_cyc - w0), 64'd4);
    check_writes("basic");
    post_done("basic");

    // len=0
    launch(8'h00, 8'h20, 8'd0, 1'b0, 32'h0);
    run(0, -1, 0, -1, 0, 0, 10, dk);
    chk("len0 done cycle", 64'(dk), 64'd1);
    chk("len0 busy at T+1", 64'(b1), 64'h1);
    chk("len0 req cycles", 64'(req_cyc - r0), 64'd0);
    check_writes("len0");
    post_done("len0");

    // Start while busy is ignored
    push_copy(8'h04, 8'h24, 2);
    launch(8'h04, 8'h24, 8'd2, 1'b0, 32'h0);
    run(0, -1, 0, -1, 0, 3, 40, dk);
    chk("busy-start done cycle", 64'(dk), 64'd8);
    check_writes("busy-start");
    post_done("busy-start");
    repeat (3) @(posedge clk);
    #1;
    chk("busy-start no relaunch", 64'(busy), 64'h0);

    // Source address wrap-around
    push_copy(8'hFE, 8'h28, 3);
    launch(8'hFE, 8'h28, 8'd3, 1'b0, 32'h0);
    run(0, -1, 0, -1, 0, 0, 40, dk);
    chk("wrap done cycle", 64'(dk), 64'd11);
    check_writes("wrap");
    post_done("wrap");

    // Grant withheld 3 cycles, then dropped during the second word's RDW
    push_copy(8'h08, 8'h2C, 3);
    launch(8'h08, 8'h2C, 8'd3, 1'b0, 32'h0);
    run(1, 3, 9, 10, 0, 0, 60, dk);
    chk("grant done cycle", 64'(dk), 64'd18);
    chk("grant wr cycles", 64'(wr_cyc - w0), 64'd3);
    check_writes("grant");
    post_done("grant");

    // Reset during the second word's WR
    push_copy(8'h00, 8'h20, 1);
    launch(8'h00, 8'h20, 8'd4, 1'b0, 32'h0);
    run(0, -1, 0, -1, 7, 0, 10, dk);
    chk("reset-mid no done", 64'(dk), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("reset-mid outputs held", {M_req, M_wr, M_addr, M_dout, busy, done}, 64'h0);
    chk("reset-mid wr cycles", 64'(wr_cyc - w0), 64'd1);
    check_writes("reset-mid");
    reset_n = 1'b1;
    @(posedge clk); #1;
    push_copy(8'h00, 8'h30, 4);
    launch(8'h00, 8'h30, 8'd4, 1'b0, 32'h0);
    run(0, -1, 0, -1, 0, 0, 40, dk);
    chk("after-reset done cycle", 64'(dk), 64'd14);
    check_writes("after-reset");
    post_done("after-reset");

    // Fill request (a copy when the feature is compiled out)
`ifdef DMA_FILL_EN
    for (int j = 0; j < 3; j++) exp_q.push_back({8'h20 + 8'(j), 32'hDEAD_BEEF});
`else
    push_copy(8'h10, 8'h20, 3);
`endif
    launch(8'h10, 8'h20, 8'd3, 1'b1, 32'hDEAD_BEEF);
    run(0, -1, 0, -1, 0, 0, 40, dk);
`ifdef DMA_FILL_EN
    chk("fill done cycle", 64'(dk), 64'd5);
`else
    chk("fill-as-copy done cycle", 64'(dk), 64'd11);
`endif
    chk("fill wr cycles", 64'(wr_cyc - w0), 64'd3);
    check_writes("fill");
    post_done("fill");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
